// File: rtl/ctrl_decode_pipe.sv
// ---------------------------------------------------------------------------
// ctrl_decode_pipe
//   Instruction buffer plus RV32I control decoder. Fetched instructions are
//   queued in a circular FIFO. The head is decoded combinationally, then
//   registered into a single output stage that the EX side drains with a
//   valid/ready handshake. A load-use hazard against the instruction in EX
//   inserts a one-cycle bubble and leaves the head in the FIFO.
//
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN
//   defined   : unsupported encodings raise illegal_o. rf_we, dram_we and
//               branch_o are forced to 0, and npc_op is PC+4.
//   undefined : illegal_o stays 0. Unsupported encodings decode as
//               addi x0,x0,0.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   inst_i/inst_valid_i/inst_ready_o   fetch-side push handshake
//   flush_i                    drop everything buffered and the output stage
//   ex_rd_i, ex_load_i         destination register / load flag of EX instr
//   out_valid_o/out_ready_i    EX-side handshake
//   npc_op .. wdin_sel         registered control word (encodings below)
//   rd_o/rs1_o/rs2_o/inst_o    raw fields / word of the issued instruction
//   illegal_o                  registered unsupported-encoding flag
//
// Encodings
//   npc_op  : 0 PC+4, 1 branch target, 2 JAL target, 3 JALR target
//   pc_sel  : 1 = next-PC base is rs1 (JALR)
//   imm_sel : 1 = the immediate generator output is consumed
//   sext_op : 0 I, 1 S, 2 B, 3 U, 4 J immediate format
//   wd_sel  : 0 ALU, 1 DRAM, 2 PC+4, 3 immediate (register write source)
//   alua_sel: 1 = operand A is PC;  alub_sel: 1 = operand B is immediate
//   wdin_sel: memory access size 0 word, 1 byte, 2 half
//   alu_op  : ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SRL 6, SRA 7,
//             SLT 8, SLTU 9, BEQ 10, BNE 11, BLT 12, BGE 13, BLTU 14,
//             BGEU 15.  ALU_OP_W must be at least 4.
// ---------------------------------------------------------------------------
module ctrl_decode_pipe #(
  parameter int FIFO_DEPTH = 4,
  parameter int ALU_OP_W   = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         inst_i,
  input  logic                inst_valid_i,
  output logic                inst_ready_o,
  input  logic                flush_i,
  input  logic [4:0]          ex_rd_i,
  input  logic                ex_load_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [1:0]          npc_op,
  output logic                pc_sel,
  output logic                imm_sel,
  output logic [2:0]          sext_op,
  output logic [2:0]          wd_sel,
  output logic                rf_we,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                alua_sel,
  output logic                alub_sel,
  output logic                dram_we,
  output logic                branch_o,
  output logic [1:0]          wdin_sel,
  output logic [4:0]          rd_o,
  output logic [4:0]          rs1_o,
  output logic [4:0]          rs2_o,
  output logic [31:0]         inst_o,
  output logic                illegal_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [1:0] NPC_PC4  = 2'd0;
  localparam logic [1:0] NPC_BR   = 2'd1;
  localparam logic [1:0] NPC_JAL  = 2'd2;
  localparam logic [1:0] NPC_JALR = 2'd3;

  localparam logic [2:0] SEXT_I = 3'd0;
  localparam logic [2:0] SEXT_S = 3'd1;
  localparam logic [2:0] SEXT_B = 3'd2;
  localparam logic [2:0] SEXT_U = 3'd3;
  localparam logic [2:0] SEXT_J = 3'd4;

  localparam logic [2:0] WD_ALU  = 3'd0;
  localparam logic [2:0] WD_DRAM = 3'd1;
  localparam logic [2:0] WD_PC4  = 3'd2;
  localparam logic [2:0] WD_IMM  = 3'd3;

  localparam logic [1:0] SIZE_W = 2'd0;
  localparam logic [1:0] SIZE_B = 2'd1;
  localparam logic [1:0] SIZE_H = 2'd2;

  localparam logic [ALU_OP_W-1:0] ALU_OP_ADD  = ALU_OP_W'(4'd0);
  localparam logic [ALU_OP_W-1:0] ALU_OP_SUB  = ALU_OP_W'(4'd1);
  localparam logic [ALU_OP_W-1:0] ALU_OP_AND  = ALU_OP_W'(4'd2);
  localparam logic [ALU_OP_W-1:0] ALU_OP_OR   = ALU_OP_W'(4'd3);
  localparam logic [ALU_OP_W-1:0] ALU_OP_XOR  = ALU_OP_W'(4'd4);
  localparam logic [ALU_OP_W-1:0] ALU_OP_SLL  = ALU_OP_W'(4'd5);
  localparam logic [ALU_OP_W-1:0] ALU_OP_SRL  = ALU_OP_W'(4'd6);
  localparam logic [ALU_OP_W-1:0] ALU_OP_SRA  = ALU_OP_W'(4'd7);
  localparam logic [ALU_OP_W-1:0] ALU_OP_SLT  = ALU_OP_W'(4'd8);
  localparam logic [ALU_OP_W-1:0] ALU_OP_SLTU = ALU_OP_W'(4'd9);
  localparam logic [ALU_OP_W-1:0] ALU_OP_BEQ  = ALU_OP_W'(4'd10);
  localparam logic [ALU_OP_W-1:0] ALU_OP_BNE  = ALU_OP_W'(4'd11);
  localparam logic [ALU_OP_W-1:0] ALU_OP_BLT  = ALU_OP_W'(4'd12);
  localparam logic [ALU_OP_W-1:0] ALU_OP_BGE  = ALU_OP_W'(4'd13);
  localparam logic [ALU_OP_W-1:0] ALU_OP_BLTU = ALU_OP_W'(4'd14);
  localparam logic [ALU_OP_W-1:0] ALU_OP_BGEU = ALU_OP_W'(4'd15);

  typedef struct packed {
    logic [1:0]          npc_op;
    logic                pc_sel;
    logic                imm_sel;
    logic [2:0]          sext_op;
    logic [2:0]          wd_sel;
    logic                rf_we;
    logic [ALU_OP_W-1:0] alu_op;
    logic                alua_sel;
    logic                alub_sel;
    logic                dram_we;
    logic                branch;
    logic [1:0]          wdin_sel;
    logic                illegal;
  } ctrl_t;

  // Control word of addi x0,x0,0.
  function automatic ctrl_t nop_ctrl();
    ctrl_t c;
    c          = '0;
    c.npc_op   = NPC_PC4;
    c.imm_sel  = 1'b1;
    c.sext_op  = SEXT_I;
    c.wd_sel   = WD_ALU;
    c.rf_we    = 1'b1;
    c.alu_op   = ALU_OP_ADD;
    c.alub_sel = 1'b1;
    return c;
  endfunction

  // Reset value: everything zero except the ALU op.
  function automatic ctrl_t reset_ctrl();
    ctrl_t c;
    c        = '0;
    c.alu_op = ALU_OP_ADD;
    return c;
  endfunction

  // Keep the datapath selects, but drop every side effect.
  function automatic ctrl_t quiet_ctrl(input ctrl_t c_in);
    ctrl_t c;
    c         = c_in;
    c.rf_we   = 1'b0;
    c.dram_we = 1'b0;
    c.branch  = 1'b0;
    c.illegal = 1'b0;
    return c;
  endfunction

  logic [31:0]      fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic [31:0]      inst_q, inst_d;

  logic [31:0] head_s;
  logic [2:0]  f3_s;
  logic [6:0]  f7_s;
  ctrl_t       dec_s;
  logic        dec_bad_s;
  logic        uses_rs2_s;
  logic        hazard_s;
  logic        push_s;
  logic        fifo_we_s;
  logic        load_s;

  assign head_s = fifo_q[rd_ptr_q];
  assign f3_s   = head_s[14:12];
  assign f7_s   = head_s[31:25];

  // rs2 is only a real source operand for R, S and B formats.
  assign uses_rs2_s = (head_s[6:0] == OP_REG) || (head_s[6:0] == OP_STORE) ||
                      (head_s[6:0] == OP_BRANCH);
  assign hazard_s   = ex_load_i && (ex_rd_i != 5'd0) &&
                      ((ex_rd_i == head_s[19:15]) ||
                       (uses_rs2_s && (ex_rd_i == head_s[24:20])));

  assign inst_ready_o = (count_q != DEPTH_C);
  assign push_s       = inst_valid_i && inst_ready_o;
  assign fifo_we_s    = push_s && !flush_i;
  // count != 0 gates the pop, so an empty FIFO never bypasses to the output.
  assign load_s       = (!valid_q || out_ready_i) && (count_q != {CNT_W{1'b0}}) &&
                        !hazard_s;

  // Combinational RV32I decode of the FIFO head.
  always_comb begin
    dec_s     = nop_ctrl();
    dec_bad_s = 1'b0;
    case (head_s[6:0])
      OP_LUI: begin
        dec_s.sext_op = SEXT_U;
        dec_s.wd_sel  = WD_IMM;
      end
      OP_AUIPC: begin
        dec_s.sext_op  = SEXT_U;
        dec_s.alua_sel = 1'b1;
      end
      OP_JAL: begin
        dec_s.npc_op  = NPC_JAL;
        dec_s.sext_op = SEXT_J;
        dec_s.wd_sel  = WD_PC4;
      end
      OP_JALR: begin
        dec_s.npc_op = NPC_JALR;
        dec_s.pc_sel = 1'b1;
        dec_s.wd_sel = WD_PC4;
        if (f3_s != 3'b000) begin
          dec_bad_s = 1'b1;
        end else begin
          dec_bad_s = 1'b0;
        end
      end
      OP_BRANCH: begin
        dec_s.npc_op   = NPC_BR;
        dec_s.sext_op  = SEXT_B;
        dec_s.rf_we    = 1'b0;
        dec_s.alub_sel = 1'b0;
        dec_s.branch   = 1'b1;
        case (f3_s)
          3'b000:  dec_s.alu_op = ALU_OP_BEQ;
          3'b001:  dec_s.alu_op = ALU_OP_BNE;
          3'b100:  dec_s.alu_op = ALU_OP_BLT;
          3'b101:  dec_s.alu_op = ALU_OP_BGE;
          3'b110:  dec_s.alu_op = ALU_OP_BLTU;
          3'b111:  dec_s.alu_op = ALU_OP_BGEU;
          default: dec_bad_s    = 1'b1;
        endcase
      end
      OP_LOAD: begin
        dec_s.wd_sel = WD_DRAM;
        case (f3_s)
          3'b000:  dec_s.wdin_sel = SIZE_B;
          3'b001:  dec_s.wdin_sel = SIZE_H;
          3'b010:  dec_s.wdin_sel = SIZE_W;
          default: dec_bad_s      = 1'b1;
        endcase
      end
      OP_STORE: begin
        dec_s.sext_op = SEXT_S;
        dec_s.rf_we   = 1'b0;
        dec_s.dram_we = 1'b1;
        case (f3_s)
          3'b000:  dec_s.wdin_sel = SIZE_B;
          3'b001:  dec_s.wdin_sel = SIZE_H;
          3'b010:  dec_s.wdin_sel = SIZE_W;
          default: dec_bad_s      = 1'b1;
        endcase
      end
      OP_IMM: begin
        case (f3_s)
          3'b000: dec_s.alu_op = ALU_OP_ADD;
          3'b010: dec_s.alu_op = ALU_OP_SLT;
          3'b011: dec_s.alu_op = ALU_OP_SLTU;
          3'b100: dec_s.alu_op = ALU_OP_XOR;
          3'b110: dec_s.alu_op = ALU_OP_OR;
          3'b111: dec_s.alu_op = ALU_OP_AND;
          3'b001: begin
            if (f7_s == 7'b0000000) begin
              dec_s.alu_op = ALU_OP_SLL;
            end else begin
              dec_bad_s = 1'b1;
            end
          end
          3'b101: begin
            if (f7_s == 7'b0000000) begin
              dec_s.alu_op = ALU_OP_SRL;
            end else if (f7_s == 7'b0100000) begin
              dec_s.alu_op = ALU_OP_SRA;
            end else begin
              dec_bad_s = 1'b1;
            end
          end
          default: dec_bad_s = 1'b1;
        endcase
      end
      OP_REG: begin
        dec_s.imm_sel  = 1'b0;
        dec_s.alub_sel = 1'b0;
        if (f7_s == 7'b0000000) begin
          case (f3_s)
            3'b000:  dec_s.alu_op = ALU_OP_ADD;
            3'b001:  dec_s.alu_op = ALU_OP_SLL;
            3'b010:  dec_s.alu_op = ALU_OP_SLT;
            3'b011:  dec_s.alu_op = ALU_OP_SLTU;
            3'b100:  dec_s.alu_op = ALU_OP_XOR;
            3'b101:  dec_s.alu_op = ALU_OP_SRL;
            3'b110:  dec_s.alu_op = ALU_OP_OR;
            3'b111:  dec_s.alu_op = ALU_OP_AND;
            default: dec_bad_s    = 1'b1;
          endcase
        end else if (f7_s == 7'b0100000) begin
          case (f3_s)
            3'b000:  dec_s.alu_op = ALU_OP_SUB;
            3'b101:  dec_s.alu_op = ALU_OP_SRA;
            default: dec_bad_s    = 1'b1;
          endcase
        end else begin
          dec_bad_s = 1'b1;
        end
      end
      default: dec_bad_s = 1'b1;
    endcase

    // Unsupported encodings fall back to NOP controls, trapping if enabled.
    if (dec_bad_s) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
      dec_s         = nop_ctrl();
      dec_s.rf_we   = 1'b0;
      dec_s.illegal = 1'b1;
`else
      dec_s         = nop_ctrl();
`endif
    end else begin
      dec_s.illegal = 1'b0;
    end
  end

  // Next-state logic for the pointers, the occupancy count and the output stage.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    ctrl_d   = ctrl_q;
    inst_d   = inst_q;
    if (flush_i) begin
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
      valid_d  = 1'b0;
      ctrl_d   = quiet_ctrl(ctrl_q);
    end else begin
      if (fifo_we_s) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1'b1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (load_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({fifo_we_s, load_s})
        2'b10:   count_d = count_q + CNT_W'(1'b1);
        2'b01:   count_d = count_q - CNT_W'(1'b1);
        default: count_d = count_q;
      endcase
      if (load_s) begin
        valid_d = 1'b1;
        ctrl_d  = dec_s;
        inst_d  = head_s;
      end else if (!valid_q || out_ready_i) begin
        // Drained or hazard bubble: nothing valid, so no side effects.
        valid_d = 1'b0;
        ctrl_d  = quiet_ctrl(ctrl_q);
      end else begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
      end
    end
  end

  // FIFO storage write; it needs no reset because the pointers and count gate it.
  always_ff @(posedge clk) begin
    if (fifo_we_s) begin
      fifo_q[wr_ptr_q] <= inst_i;
    end
  end

  // Pipeline state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      valid_q  <= 1'b0;
      ctrl_q   <= reset_ctrl();
      inst_q   <= NOP_INST;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      ctrl_q   <= ctrl_d;
      inst_q   <= inst_d;
    end
  end

  assign out_valid_o = valid_q;
  assign npc_op      = ctrl_q.npc_op;
  assign pc_sel      = ctrl_q.pc_sel;
  assign imm_sel     = ctrl_q.imm_sel;
  assign sext_op     = ctrl_q.sext_op;
  assign wd_sel      = ctrl_q.wd_sel;
  assign rf_we       = ctrl_q.rf_we;
  assign alu_op      = ctrl_q.alu_op;
  assign alua_sel    = ctrl_q.alua_sel;
  assign alub_sel    = ctrl_q.alub_sel;
  assign dram_we     = ctrl_q.dram_we;
  assign branch_o    = ctrl_q.branch;
  assign wdin_sel    = ctrl_q.wdin_sel;
  assign illegal_o   = ctrl_q.illegal;
  assign inst_o      = inst_q;
  assign rd_o        = inst_q[11:7];
  assign rs1_o       = inst_q[19:15];
  assign rs2_o       = inst_q[24:20];

endmodule
